// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with hardware return stack
//
// Produces the next instruction address from the control unit's
// jump/call/return strobes and keeps a small LIFO of return addresses.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_en         global enable
//   i_PCw        PC write strobe; nothing changes without it
//   i_jump       branch request
//   i_j_mode     branch condition: 00 always, 01 zero, 10 carry, 11 not zero
//   i_call       with a taken jump, push the return address
//   i_return     pop the return address into the PC (highest priority)
//   i_target     branch/call destination
//   i_zero       status zero flag
//   i_carry      status carry flag
//   o_pc         current program counter
//   o_sp         number of valid stack entries
//   o_overflow   sticky: call while stack full (guarded build only)
//   o_underflow  sticky: return while stack empty (guarded build only)
//
// Build option PC_SEQUENCER_STACK_GUARD_EN:
//   defined   - full/empty stack accesses are refused and flagged
//   undefined - circular stack, o_sp saturates, flags tied low

module pc_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_PCw,
  input  logic                           i_jump,
  input  logic [1:0]                     i_j_mode,
  input  logic                           i_call,
  input  logic                           i_return,
  input  logic [ADDR_WIDTH-1:0]          i_target,
  input  logic                           i_zero,
  input  logic                           i_carry,
  output logic [ADDR_WIDTH-1:0]          o_pc,
  output logic [$clog2(STACK_DEPTH):0]   o_sp,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic                  upd;
  logic                  cond_ok;
  logic                  taken;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [SP_W-1:0]       sp_dec;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;

  logic [ADDR_WIDTH-1:0] pc_nxt;
  logic [SP_W-1:0]       sp_nxt;
  logic                  push;
  logic                  ovf_set;
  logic                  unf_set;

  assign upd    = i_en & i_PCw;
  assign pc_inc = o_pc + ADDR_WIDTH'(1);
  assign full   = (o_sp == SP_W'(STACK_DEPTH));
  assign empty  = (o_sp == '0);
  assign sp_dec = o_sp - SP_W'(1);
  // Index wraps: pop when empty reads the last slot, push when full writes slot 0.
  assign rd_idx = sp_dec[IDX_W-1:0];
  assign wr_idx = o_sp[IDX_W-1:0];

  always_comb begin
    cond_ok = 1'b1;
    case (i_j_mode)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = i_zero;
      2'b10:   cond_ok = i_carry;
      default: cond_ok = ~i_zero;
    endcase
  end

  assign taken = i_jump & cond_ok;

  always_comb begin
    pc_nxt  = o_pc;
    sp_nxt  = o_sp;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (upd) begin
      if (i_return) begin
`ifdef PC_SEQUENCER_STACK_GUARD_EN
        if (empty) begin
          pc_nxt  = pc_inc;
          unf_set = 1'b1;
        end else begin
          pc_nxt = stack_q[rd_idx];
          sp_nxt = sp_dec;
        end
`else
        pc_nxt = stack_q[rd_idx];
        if (!empty) sp_nxt = sp_dec;
`endif
      end else if (taken) begin
        pc_nxt = i_target;
        if (i_call) begin
`ifdef PC_SEQUENCER_STACK_GUARD_EN
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push   = 1'b1;
            sp_nxt = o_sp + SP_W'(1);
          end
`else
          push = 1'b1;
          if (!full) sp_nxt = o_sp + SP_W'(1);
`endif
        end
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc <= '0;
      o_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      o_pc <= pc_nxt;
      o_sp <= sp_nxt;
      if (push) stack_q[wr_idx] <= pc_inc;
    end
  end

`ifdef PC_SEQUENCER_STACK_GUARD_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (ovf_set) o_overflow  <= 1'b1;
      if (unf_set) o_underflow <= 1'b1;
    end
  end
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer

module tb_pc_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_en;
  logic       i_PCw;
  logic       i_jump;
  logic [1:0] i_j_mode;
  logic       i_call;
  logic       i_return;
  logic [9:0] i_target;
  logic       i_zero;
  logic       i_carry;
  logic [9:0] o_pc;
  logic [2:0] o_sp;
  logic       o_overflow;
  logic       o_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.ADDR_WIDTH(10), .STACK_DEPTH(4)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_PCw      (i_PCw),
    .i_jump     (i_jump),
    .i_j_mode   (i_j_mode),
    .i_call     (i_call),
    .i_return   (i_return),
    .i_target   (i_target),
    .i_zero     (i_zero),
    .i_carry    (i_carry),
    .o_pc       (o_pc),
    .o_sp       (o_sp),
    .o_overflow (o_overflow),
    .o_underflow(o_underflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic jump, input logic [1:0] mode, input logic call,
                    input logic ret, input logic [9:0] tgt, input logic zero,
                    input logic carry);
    i_jump   = jump;
    i_j_mode = mode;
    i_call   = call;
    i_return = ret;
    i_target = tgt;
    i_zero   = zero;
    i_carry  = carry;
    i_PCw    = 1'b1;
    @(posedge i_clk);
    #1;
    i_PCw    = 1'b0;
    i_jump   = 1'b0;
    i_call   = 1'b0;
    i_return = 1'b0;
  endtask

  task automatic inc();
    op(1'b0, 2'b00, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
  endtask

  task automatic jmp(input logic [9:0] tgt);
    op(1'b1, 2'b00, 1'b0, 1'b0, tgt, 1'b0, 1'b0);
  endtask

  task automatic call_to(input logic [9:0] tgt);
    op(1'b1, 2'b00, 1'b1, 1'b0, tgt, 1'b0, 1'b0);
  endtask

  task automatic ret();
    op(1'b0, 2'b00, 1'b0, 1'b1, 10'h000, 1'b0, 1'b0);
  endtask

  task automatic chk_pc_sp(input string tag, input logic [9:0] pc, input logic [2:0] sp);
    check({tag, "_pc"}, 32'(o_pc), 32'(pc));
    check({tag, "_sp"}, 32'(o_sp), 32'(sp));
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_PCw = 1'b0; i_jump = 1'b0; i_j_mode = 2'b00;
    i_call = 1'b0; i_return = 1'b0; i_target = '0; i_zero = 1'b0; i_carry = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_pc_sp("reset", 10'h000, 3'd0);
    check("reset_ovf", 32'(o_overflow), 32'd0);
    check("reset_unf", 32'(o_underflow), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // plain increments
    inc(); check("inc1", 32'(o_pc), 32'h001);
    inc(); check("inc2", 32'(o_pc), 32'h002);
    inc(); chk_pc_sp("inc3", 10'h003, 3'd0);
    inc(); inc();
    check("at5", 32'(o_pc), 32'h005);

    // conditional jumps
    op(1'b1, 2'b01, 1'b0, 1'b0, 10'h040, 1'b0, 1'b0); check("jz_not", 32'(o_pc), 32'h006);
    op(1'b1, 2'b01, 1'b0, 1'b0, 10'h040, 1'b1, 1'b0); check("jz_yes", 32'(o_pc), 32'h040);
    op(1'b1, 2'b10, 1'b0, 1'b0, 10'h100, 1'b0, 1'b0); check("jc_not", 32'(o_pc), 32'h041);
    op(1'b1, 2'b10, 1'b0, 1'b0, 10'h100, 1'b0, 1'b1); check("jc_yes", 32'(o_pc), 32'h100);
    op(1'b1, 2'b11, 1'b0, 1'b0, 10'h200, 1'b1, 1'b0); check("jnz_not", 32'(o_pc), 32'h101);
    op(1'b1, 2'b11, 1'b0, 1'b0, 10'h010, 1'b0, 1'b0); check("jnz_yes", 32'(o_pc), 32'h010);

    // call / return
    call_to(10'h080); chk_pc_sp("call", 10'h080, 3'd1);
    ret();            chk_pc_sp("ret", 10'h011, 3'd0);

    // call without a taken jump does not push
    op(1'b1, 2'b01, 1'b1, 1'b0, 10'h0AA, 1'b0, 1'b0); chk_pc_sp("call_nt", 10'h012, 3'd0);
    op(1'b0, 2'b00, 1'b1, 1'b0, 10'h0AA, 1'b0, 1'b0); chk_pc_sp("call_nj", 10'h013, 3'd0);

    // return wins over call
    call_to(10'h200); chk_pc_sp("call2", 10'h200, 3'd1);
    op(1'b1, 2'b00, 1'b1, 1'b1, 10'h300, 1'b0, 1'b0); chk_pc_sp("ret_call", 10'h014, 3'd0);

    // five nested calls into a four-deep stack
    call_to(10'h050);
    call_to(10'h060);
    call_to(10'h070);
    call_to(10'h080); chk_pc_sp("nest4", 10'h080, 3'd4);
    call_to(10'h090); chk_pc_sp("nest5", 10'h090, 3'd4);
`ifdef PC_SEQUENCER_STACK_GUARD_EN
    check("nest5_ovf", 32'(o_overflow), 32'd1);
    ret(); chk_pc_sp("unw1", 10'h071, 3'd3);
    ret(); chk_pc_sp("unw2", 10'h061, 3'd2);
    ret(); chk_pc_sp("unw3", 10'h051, 3'd1);
    ret(); chk_pc_sp("unw4", 10'h015, 3'd0);
    check("unw4_unf", 32'(o_underflow), 32'd0);
    ret(); chk_pc_sp("unw5", 10'h016, 3'd0);
    check("unw5_unf", 32'(o_underflow), 32'd1);
`else
    check("nest5_ovf", 32'(o_overflow), 32'd0);
    ret(); chk_pc_sp("unw1", 10'h071, 3'd3);
    ret(); chk_pc_sp("unw2", 10'h061, 3'd2);
    ret(); chk_pc_sp("unw3", 10'h051, 3'd1);
    ret(); chk_pc_sp("unw4", 10'h081, 3'd0);
    ret(); chk_pc_sp("unw5", 10'h071, 3'd0);
    check("unw5_unf", 32'(o_underflow), 32'd0);
`endif

    // address wrap
    jmp(10'h3FF); check("at3ff", 32'(o_pc), 32'h3FF);
    inc();        check("wrap", 32'(o_pc), 32'h000);
    jmp(10'h3FF);
    call_to(10'h123); chk_pc_sp("wcall", 10'h123, 3'd1);
    ret();            chk_pc_sp("wret", 10'h000, 3'd0);

    // asynchronous reset between edges
    call_to(10'h055); chk_pc_sp("pre_rst", 10'h055, 3'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk_pc_sp("mid_rst", 10'h000, 3'd0);
    check("mid_rst_ovf", 32'(o_overflow), 32'd0);
    check("mid_rst_unf", 32'(o_underflow), 32'd0);
    i_rst_n = 1'b1;

    // stack contents were cleared by reset
    ret();
`ifdef PC_SEQUENCER_STACK_GUARD_EN
    chk_pc_sp("rst_pop", 10'h001, 3'd0);
`else
    chk_pc_sp("rst_pop", 10'h000, 3'd0);
`endif
    jmp(10'h020); check("pre_en", 32'(o_pc), 32'h020);

    // enable low holds everything
    i_en = 1'b0;
    inc();
    inc();
    jmp(10'h1F0);
    call_to(10'h1F0);
    chk_pc_sp("en_hold", 10'h020, 3'd0);
    i_en = 1'b1;
    inc(); check("en_resume", 32'(o_pc), 32'h021);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and return-stack block that consumes the jump/call/return strobes issued by the control unit and produces the next instruction address. It sits between the control unit and program memory. On every write-enabled cycle it increments, branches, calls or returns, and it keeps a hardware return stack for nested calls.

## Interface
Parameters:
- ADDR_WIDTH, 10, program-counter and target width.
- STACK_DEPTH, 4, number of return-address entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  global enable; when low, all state holds.
- i_PCw  in  1  PC write strobe from the control unit; no state changes without it.
- i_jump  in  1  branch request.
- i_j_mode  in  2  branch condition: 00 always, 01 if zero, 10 if carry, 11 if not zero.
- i_call  in  1  with a taken jump, push the return address.
- i_return  in  1  pop the return address into the PC.
- i_target  in  ADDR_WIDTH  branch/call destination.
- i_zero  in  1  status zero flag.
- i_carry  in  1  status carry flag.
- o_pc  out  ADDR_WIDTH  current program counter (registered).
- o_sp  out  clog2(STACK_DEPTH)+1  number of valid stack entries.
- o_overflow  out  1  sticky flag: call attempted while the stack was full.
- o_underflow  out  1  sticky flag: return attempted while the stack was empty.

## Operation
- Update happens only when i_en=1 and i_PCw=1. Priority: return, then taken jump, then increment.
- Taken jump: i_jump=1 and the condition selected by i_j_mode holds. A not-taken jump increments the PC.
- Increment: o_pc <= o_pc+1, modulo 2^ADDR_WIDTH. Address max wraps to 0.
- Taken jump with i_call=0: o_pc <= i_target.
- Taken jump with i_call=1:
  - Push o_pc+1, wrapped, onto the stack.
  - o_pc <= i_target.
  - o_sp increments.
- i_call with a not-taken jump, or with i_jump=0: no push.
- Return with a non-empty stack: o_pc <= top entry and o_sp decrements.
- i_return and i_call asserted together: the return wins, and the call and jump are ignored.
- Stack is LIFO. Storage is STACK_DEPTH registers indexed by o_sp.
- Full or empty boundaries are governed by the configuration macro (see Configuration).
- Sticky flags clear only on reset.

## Timing
- Reset values, applied asynchronously while i_rst_n=0:
  - o_pc=0, o_sp=0, o_overflow=0, o_underflow=0.
  - All stack entries 0.
- Latency: a strobe sampled at edge N is visible on o_pc, o_sp and the flags after edge N, within the same cycle. There is no further pipeline.
- i_zero and i_carry are sampled on the same edge as i_PCw.
- Reset asserted mid-call: everything returns to reset values immediately. A partially pushed entry is discarded.
- The first rising edge after i_rst_n deasserts performs a normal update if the strobes are present.
- i_en=0 with i_PCw=1: no change.

## Configuration
- Macro: PC_SEQUENCER_STACK_GUARD_EN.
- Defined:
  - Call when o_sp==STACK_DEPTH: no push and o_sp unchanged; the jump is still taken; o_overflow<=1.
  - Return when o_sp==0: o_pc increments instead; o_underflow<=1.
- Undefined:
  - The stack is circular; a push when full overwrites the oldest entry.
  - o_sp saturates at STACK_DEPTH, and a pop when empty leaves it at 0.
  - A pop when empty loads the stored entry at the wrapped index.
  - o_overflow and o_underflow are tied 0.

## Test plan
- Reset, then 3 plain i_PCw pulses -> o_pc = 0, 1, 2, 3; o_sp=0; flags 0.
- o_pc=5, jump with j_mode=01, i_zero=0, target 0x40 -> o_pc=6. Repeat with i_zero=1 -> o_pc=0x40.
- o_pc=0x10, call to 0x80, then return -> o_pc=0x80 with o_sp=1; then o_pc=0x11 with o_sp=0.
- Guard enabled, STACK_DEPTH=4: 5 nested calls -> o_sp=4, o_overflow=1, o_pc equals the 5th target. Then 4 returns unwind the addresses correctly, and a 5th return -> o_underflow=1 and o_pc increments.
- o_pc=0x3FF with a plain increment -> o_pc=0x000. Call at o_pc=0x3FF -> pushed value 0x000.
- Mid-sequence i_rst_n low for 1 ns between edges -> o_pc=0 and o_sp=0 immediately. i_en=0 with i_PCw pulses -> o_pc holds.
